// File: rtl/perlin_scan_driver.sv
// rtl/perlin_scan_driver.sv - VGA raster counters, frame time and aligned sync for the Perlin pixel path
//
// Generates x/y raster coordinates and the per-frame animation time t that
// feed the noise generator, plus hsync/vsync/display_on lined up with the
// generator's registered noise output.
//
// Ports:
//   clk          in   1   pixel clock
//   rst          in   1   asynchronous reset, active-high
//   speed        in   4   amount added to t on each frame wrap
//   x            out  10  horizontal counter, 0..H_TOTAL-1
//   y            out  10  vertical counter, 0..V_TOTAL-1
//   t            out  16  frame time accumulator (wraps mod 2^16)
//   frame_start  out  1   x==0 && y==0, undelayed
//   hsync        out  1   horizontal sync, active-low, aligned to noise
//   vsync        out  1   vertical sync, active-low, aligned to noise
//   display_on   out  1   visible-area flag, aligned to noise
//
// Build option: PERLIN_SCAN_DELAY_EN
//   defined   - sync/display flags pass through a PIPE_DELAY-stage delay line
//   undefined - sync/display flags are the raw counter decode, no delay

module perlin_scan_driver #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  speed,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [15:0] t,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic        display_on
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

`ifdef PERLIN_SCAN_DELAY_EN
  localparam int DELAY = PIPE_DELAY;
`else
  // Without the delay line the flags are combinational; PIPE_DELAY has no effect.
  localparam int DELAY = PIPE_DELAY * 0;
`endif

  // Sync/display flags packed as {hs, vs, de}; reset value of each delay stage.
  localparam logic [2:0] FLAGS_RESET = 3'b110;

  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [15:0] t_q, t_d;

  logic        hs_raw;
  logic        vs_raw;
  logic        de_raw;
  logic [2:0]  flags_raw;

  // Line wrap and frame wrap resolve in one step, so y never shows V_TOTAL.
  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    t_d = t_q;
    if (x_q == X_LAST) begin
      x_d = 10'd0;
      if (y_q == Y_LAST) begin
        y_d = 10'd0;
        // speed only matters on this edge; it is ignored the rest of the frame
        t_d = t_q + {12'd0, speed};
      end else begin
        y_d = y_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= 10'd0;
      y_q <= 10'd0;
      t_q <= 16'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      t_q <= t_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign t           = t_q;
  assign frame_start = (x_q == 10'd0) && (y_q == 10'd0);

  assign hs_raw    = ~((x_q >= HS_START) && (x_q < HS_END));
  assign vs_raw    = ~((y_q >= VS_START) && (y_q < VS_END));
  assign de_raw    = (x_q < X_VIS) && (y_q < Y_VIS);
  assign flags_raw = {hs_raw, vs_raw, de_raw};

  if (DELAY == 0) begin : g_direct
    assign {hsync, vsync, display_on} = flags_raw;
  end else begin : g_delay
    // Stage 0 holds the newest sample; the last stage drives the outputs.
    logic [2:0] pipe_q [DELAY];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DELAY; i++) begin
          pipe_q[i] <= FLAGS_RESET;
        end
      end else begin
        pipe_q[0] <= flags_raw;
        for (int i = 1; i < DELAY; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign {hsync, vsync, display_on} = pipe_q[DELAY-1];
  end

endmodule

// File: tb/tb_perlin_scan_driver.sv
// tb/tb_perlin_scan_driver.sv - scoreboard bench for perlin_scan_driver

module tb_perlin_scan_driver;

  // Instance A: small raster with all porches non-zero.
  localparam int A_HD = 8, A_HF = 2, A_HS = 3, A_HB = 3;
  localparam int A_VD = 5, A_VF = 2, A_VS = 2, A_VB = 2;
  localparam int A_PD = 3;
  // Instance B: 2x2 raster (4-clock frame) so t wraps 16 bits in a short run.
  localparam int B_HD = 1, B_HF = 0, B_HS = 1, B_HB = 0;
  localparam int B_VD = 1, B_VF = 0, B_VS = 1, B_VB = 0;
  localparam int B_PD = 2;

  localparam int N_CYCLES = 20000;

`ifdef PERLIN_SCAN_DELAY_EN
  localparam bit DLY = 1'b1;
`else
  localparam bit DLY = 1'b0;
`endif

  logic        clk;
  logic        rst_a, rst_b;
  logic [3:0]  speed_a, speed_b;
  logic [9:0]  xa, ya, xb, yb;
  logic [15:0] ta, tb;
  logic        fsa, hsa, vsa, dea;
  logic        fsb, hsb, vsb, deb;

  perlin_scan_driver #(
    .H_DISPLAY(A_HD), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
    .V_DISPLAY(A_VD), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
    .PIPE_DELAY(A_PD)
  ) dut_a (
    .clk(clk), .rst(rst_a), .speed(speed_a),
    .x(xa), .y(ya), .t(ta), .frame_start(fsa),
    .hsync(hsa), .vsync(vsa), .display_on(dea)
  );

  perlin_scan_driver #(
    .H_DISPLAY(B_HD), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_DISPLAY(B_VD), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
    .PIPE_DELAY(B_PD)
  ) dut_b (
    .clk(clk), .rst(rst_b), .speed(speed_b),
    .x(xb), .y(yb), .t(tb), .frame_start(fsb),
    .hsync(hsb), .vsync(vsb), .display_on(deb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int x; int y; int t; int fs; int hs; int vs; int de;
  } exp_t;

  int hd [2] = '{A_HD, B_HD};
  int hf [2] = '{A_HF, B_HF};
  int hsw[2] = '{A_HS, B_HS};
  int ht [2] = '{A_HD + A_HF + A_HS + A_HB, B_HD + B_HF + B_HS + B_HB};
  int vd [2] = '{A_VD, B_VD};
  int vf [2] = '{A_VF, B_VF};
  int vsw[2] = '{A_VS, B_VS};
  int vt [2] = '{A_VD + A_VF + A_VS + A_VB, B_VD + B_VF + B_VS + B_VB};
  int pd [2] = '{A_PD, B_PD};

  int         pix_m [2];   // clocks since the start of the current frame
  int         t_m   [2];
  logic [2:0] hist  [2][8]; // hist[i][k]: raw flags k+1 clocks ago (pre-reset = 110)

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [2:0] raw_of(int id, int n);
    int xx, yy;
    logic h, v, d;
    xx = n % ht[id];
    yy = n / ht[id];
    h = !(xx >= hd[id] + hf[id] && xx < hd[id] + hf[id] + hsw[id]);
    v = !(yy >= vd[id] + vf[id] && yy < vd[id] + vf[id] + vsw[id]);
    d = (xx < hd[id]) && (yy < vd[id]);
    return {h, v, d};
  endfunction

  task automatic model_reset(int id);
    pix_m[id] = 0;
    t_m[id]   = 0;
    for (int k = 0; k < 8; k++) hist[id][k] = 3'b110;
  endtask

  // One rising edge, given the rst/speed values present at that edge.
  task automatic model_edge(int id, logic r, logic [3:0] s);
    if (!r) begin
      for (int k = 7; k > 0; k--) hist[id][k] = hist[id][k-1];
      hist[id][0] = raw_of(id, pix_m[id]);
      if (pix_m[id] == ht[id] * vt[id] - 1) t_m[id] = (t_m[id] + int'(s)) % 65536;
      pix_m[id] = (pix_m[id] + 1) % (ht[id] * vt[id]);
    end
  endtask

  function automatic exp_t expect_of(int id);
    exp_t e;
    logic [2:0] f;
    e.x  = pix_m[id] % ht[id];
    e.y  = pix_m[id] / ht[id];
    e.t  = t_m[id];
    e.fs = (pix_m[id] == 0) ? 1 : 0;
    f = DLY ? hist[id][pd[id]-1] : raw_of(id, pix_m[id]);
    e.hs = int'(f[2]);
    e.vs = int'(f[1]);
    e.de = int'(f[0]);
    return e;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_a_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        e = q_a.pop_front();
        chk("a_x",  int'(xa),  e.x);
        chk("a_y",  int'(ya),  e.y);
        chk("a_t",  int'(ta),  e.t);
        chk("a_frame_start", int'(fsa), e.fs);
        chk("a_hsync", int'(hsa), e.hs);
        chk("a_vsync", int'(vsa), e.vs);
        chk("a_display_on", int'(dea), e.de);
      end
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_b_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        e = q_b.pop_front();
        chk("b_x",  int'(xb),  e.x);
        chk("b_y",  int'(yb),  e.y);
        chk("b_t",  int'(tb),  e.t);
        chk("b_frame_start", int'(fsb), e.fs);
        chk("b_hsync", int'(hsb), e.hs);
        chk("b_vsync", int'(vsb), e.vs);
        chk("b_display_on", int'(deb), e.de);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int hold_a, hold_b;
    rst_a = 1'b1; rst_b = 1'b1;
    speed_a = 4'd0; speed_b = 4'd0;
    hold_a = 3; hold_b = 2;
    model_reset(0);
    model_reset(1);

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(posedge clk);
      #2;
      model_edge(0, rst_a, speed_a);
      model_edge(1, rst_b, speed_b);

      // A: speed changes every clock; short resets land at random raster positions.
      if (hold_a == 0 && cyc > 10 && ($urandom % 700) == 0) hold_a = $urandom_range(1, 3);
      rst_a = (hold_a > 0);
      if (hold_a > 0) hold_a--;
      speed_a = (($urandom % 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));

      // B: hold speed=15 long enough to carry t past 0xFFFF, then randomize.
      if (cyc == 19000) hold_b = 3;
      rst_b = (hold_b > 0);
      if (hold_b > 0) hold_b--;
      speed_b = (cyc < 18000) ? 4'd15 : 4'($urandom_range(0, 15));

      if (rst_a) model_reset(0);
      if (rst_b) model_reset(1);
      q_a.push_back(expect_of(0));
      q_b.push_back(expect_of(1));
    end

    @(negedge clk);
    #1;
    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
